// File: rtl/multicycle_ctrl.sv
// Moore FSM sequencing the shared-ALU/shared-memory multicycle datapath (FETCH..WB).
// Memory accesses hold their request until mem_ready; an extra wait cycle costs one extra cycle.
module multicycle_ctrl #(
  parameter bit TRAP_ON_ILLEGAL = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       pc_write_cond,
  output logic       branch_ne,
  output logic       i_or_d,
  output logic       ir_write,
  output logic       mem_read,
  output logic       mem_write,
  output logic       reg_write,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [3:0] alu_op,
  output logic       sign_ext,
  output logic [1:0] pc_source,
  output logic       instr_done,
  output logic       illegal,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    IDLE = 4'd0, FETCH = 4'd1, DECODE = 4'd2, EXEC_R = 4'd3, EXEC_I = 4'd4,
    WB_ALU = 4'd5, MEM_ADDR = 4'd6, MEM_RD = 4'd7, MEM_WB = 4'd8, MEM_WR = 4'd9,
    BRANCH = 4'd10, JUMP = 4'd11, TRAP = 4'd12
  } state_t;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_BNE  = 6'b000101;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_ADDIU= 6'b001001;
  localparam logic [5:0] OP_ANDI = 6'b001100;
  localparam logic [5:0] OP_ORI  = 6'b001101;
  localparam logic [5:0] OP_XORI = 6'b001110;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;

  state_t state_q, state_d;
  logic   is_r_q, is_r_d, is_bne_q, is_bne_d, is_lw_q, is_lw_d, shift_imm_q, shift_imm_d;

  // zero is consumed by the datapath's conditional PC load, not by the sequencer.
  logic unused_zero;
  assign unused_zero = zero;

  logic       r_legal, r_shift_imm, i_alu, i_sext;
  logic [3:0] r_alu_op, i_alu_op;

  always_comb begin
    r_legal     = 1'b1;
    r_shift_imm = 1'b0;
    r_alu_op    = 4'b0000;
    case (funct)
      6'b100000: r_alu_op = 4'b0000;
      6'b100001: r_alu_op = 4'b0001;
      6'b100010: r_alu_op = 4'b0010;
      6'b100011: r_alu_op = 4'b0011;
      6'b100100: r_alu_op = 4'b0100;
      6'b100101: r_alu_op = 4'b0101;
      6'b100110: r_alu_op = 4'b0110;
      6'b100111: r_alu_op = 4'b0111;
      6'b101010: r_alu_op = 4'b1000;
      6'b101011: r_alu_op = 4'b1001;
      6'b000000: begin r_alu_op = 4'b1010; r_shift_imm = 1'b1; end
      6'b000010: begin r_alu_op = 4'b1011; r_shift_imm = 1'b1; end
      6'b000011: begin r_alu_op = 4'b1100; r_shift_imm = 1'b1; end
      6'b000100: r_alu_op = 4'b1010;
      6'b000110: r_alu_op = 4'b1011;
      6'b000111: r_alu_op = 4'b1100;
      default:   r_legal  = 1'b0;
    endcase
  end

  always_comb begin
    i_alu    = 1'b1;
    i_sext   = 1'b0;
    i_alu_op = 4'b0000;
    case (op)
      OP_ADDI:  begin i_alu_op = 4'b0000; i_sext = 1'b1; end
      OP_ADDIU: begin i_alu_op = 4'b0001; i_sext = 1'b1; end
      OP_ANDI:  i_alu_op = 4'b0100;
      OP_ORI:   i_alu_op = 4'b0101;
      OP_XORI:  i_alu_op = 4'b0110;
      default:  i_alu    = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      is_r_q      <= 1'b0;
      is_bne_q    <= 1'b0;
      is_lw_q     <= 1'b0;
      shift_imm_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      is_r_q      <= is_r_d;
      is_bne_q    <= is_bne_d;
      is_lw_q     <= is_lw_d;
      shift_imm_q <= shift_imm_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    is_r_d      = is_r_q;
    is_bne_d    = is_bne_q;
    is_lw_d     = is_lw_q;
    shift_imm_d = shift_imm_q;
    case (state_q)
      IDLE:   state_d = FETCH;
      FETCH:  state_d = mem_ready ? DECODE : FETCH;
      DECODE: begin
        is_r_d      = (op == OP_R);
        is_bne_d    = (op == OP_BNE);
        is_lw_d     = (op == OP_LW);
        shift_imm_d = (op == OP_R) && r_shift_imm;
        if (op == OP_R && r_legal)              state_d = EXEC_R;
        else if (i_alu)                         state_d = EXEC_I;
        else if (op == OP_LW || op == OP_SW)    state_d = MEM_ADDR;
        else if (op == OP_BEQ || op == OP_BNE)  state_d = BRANCH;
        else if (op == OP_J)                    state_d = JUMP;
        else                                    state_d = TRAP_ON_ILLEGAL ? TRAP : FETCH;
      end
      EXEC_R, EXEC_I: state_d = WB_ALU;
      MEM_ADDR:       state_d = is_lw_q ? MEM_RD : MEM_WR;
      MEM_RD:         state_d = mem_ready ? MEM_WB : MEM_RD;
      MEM_WR:         state_d = mem_ready ? FETCH : MEM_WR;
      TRAP:           state_d = TRAP;
      default:        state_d = FETCH;
    endcase
  end

  always_comb begin
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    branch_ne     = 1'b0;
    i_or_d        = 1'b0;
    ir_write      = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    reg_write     = 1'b0;
    reg_dst       = 1'b0;
    mem_to_reg    = 1'b0;
    alu_src_a     = 2'b00;
    alu_src_b     = 2'b00;
    alu_op        = 4'b0000;
    sign_ext      = 1'b0;
    pc_source     = 2'b00;
    instr_done    = 1'b0;
    illegal       = 1'b0;
    state         = state_q;
    case (state_q)
      FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = 2'b01;
        alu_op    = 4'b0001;
        ir_write  = mem_ready;
        pc_write  = mem_ready;
      end
      DECODE: begin
        alu_src_b = 2'b11;
        alu_op    = 4'b0001;
        sign_ext  = 1'b1;
      end
      EXEC_R: begin
        alu_src_a = shift_imm_q ? 2'b10 : 2'b01;
        alu_op    = r_alu_op;
      end
      EXEC_I: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b10;
        alu_op    = i_alu_op;
        sign_ext  = i_sext;
      end
      WB_ALU: begin
        reg_write  = 1'b1;
        reg_dst    = is_r_q;
        instr_done = 1'b1;
      end
      MEM_ADDR: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b10;
        alu_op    = 4'b0001;
        sign_ext  = 1'b1;
      end
      MEM_RD: begin
        mem_read = 1'b1;
        i_or_d   = 1'b1;
      end
      MEM_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        instr_done = 1'b1;
      end
      MEM_WR: begin
        mem_write  = 1'b1;
        i_or_d     = 1'b1;
        instr_done = mem_ready;
      end
      BRANCH: begin
        alu_src_a     = 2'b01;
        alu_op        = 4'b0010;
        pc_write_cond = 1'b1;
        branch_ne     = is_bne_q;
        pc_source     = 2'b01;
        instr_done    = 1'b1;
      end
      JUMP: begin
        pc_write   = 1'b1;
        pc_source  = 2'b10;
        instr_done = 1'b1;
      end
      TRAP:    illegal = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl: per-cycle vector table plus reset/illegal sequences, two parameterisations.
module tb_multicycle_ctrl;

  typedef struct packed {
    logic       pc_write, pc_write_cond, branch_ne, i_or_d, ir_write;
    logic       mem_read, mem_write, reg_write, reg_dst, mem_to_reg;
    logic [1:0] alu_src_a, alu_src_b;
    logic [3:0] alu_op;
    logic       sign_ext;
    logic [1:0] pc_source;
    logic       instr_done, illegal;
    logic [3:0] state;
  } ctl_t;

  typedef struct packed {
    logic       rst_n;
    logic [5:0] op, funct;
    logic       mem_ready;
    ctl_t       exp;
  } vec_t;

  typedef struct packed { ctl_t e1; ctl_t e0; } pair_t;

  localparam logic [3:0] S_IDLE = 4'd0, S_FETCH = 4'd1, S_DECODE = 4'd2, S_EXEC_R = 4'd3,
                         S_EXEC_I = 4'd4, S_WB_ALU = 4'd5, S_MEM_ADDR = 4'd6, S_MEM_RD = 4'd7,
                         S_MEM_WB = 4'd8, S_MEM_WR = 4'd9, S_BRANCH = 4'd10, S_JUMP = 4'd11,
                         S_TRAP = 4'd12;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [5:0] op, funct;
  logic       zero, mem_ready;

  logic       pw1, pwc1, bne1, iod1, irw1, mr1, mw1, rw1, rd1, m2r1, se1, done1, ill1;
  logic [1:0] sa1, sb1, ps1;
  logic [3:0] ao1, st1;
  logic       pw0, pwc0, bne0, iod0, irw0, mr0, mw0, rw0, rd0, m2r0, se0, done0, ill0;
  logic [1:0] sa0, sb0, ps0;
  logic [3:0] ao0, st0;

  always #5 clk = ~clk;

  multicycle_ctrl #(.TRAP_ON_ILLEGAL(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .op(op), .funct(funct), .zero(zero), .mem_ready(mem_ready),
    .pc_write(pw1), .pc_write_cond(pwc1), .branch_ne(bne1), .i_or_d(iod1), .ir_write(irw1),
    .mem_read(mr1), .mem_write(mw1), .reg_write(rw1), .reg_dst(rd1), .mem_to_reg(m2r1),
    .alu_src_a(sa1), .alu_src_b(sb1), .alu_op(ao1), .sign_ext(se1), .pc_source(ps1),
    .instr_done(done1), .illegal(ill1), .state(st1)
  );

  multicycle_ctrl #(.TRAP_ON_ILLEGAL(1'b0)) dut_nop (
    .clk(clk), .rst_n(rst_n), .op(op), .funct(funct), .zero(zero), .mem_ready(mem_ready),
    .pc_write(pw0), .pc_write_cond(pwc0), .branch_ne(bne0), .i_or_d(iod0), .ir_write(irw0),
    .mem_read(mr0), .mem_write(mw0), .reg_write(rw0), .reg_dst(rd0), .mem_to_reg(m2r0),
    .alu_src_a(sa0), .alu_src_b(sb0), .alu_op(ao0), .sign_ext(se0), .pc_source(ps0),
    .instr_done(done0), .illegal(ill0), .state(st0)
  );

  ctl_t got1, got0;
  assign got1 = {pw1, pwc1, bne1, iod1, irw1, mr1, mw1, rw1, rd1, m2r1, sa1, sb1, ao1, se1, ps1, done1, ill1, st1};
  assign got0 = {pw0, pwc0, bne0, iod0, irw0, mr0, mw0, rw0, rd0, m2r0, sa0, sb0, ao0, se0, ps0, done0, ill0, st0};

  int    n_cmp = 0, n_bad = 0, step_no = 0;
  pair_t sbq[$];
  vec_t  vecs[$];

  function automatic ctl_t x_idle();
    ctl_t c = '0; c.state = S_IDLE; return c;
  endfunction
  function automatic ctl_t x_fetch(logic rdy);
    ctl_t c = '0; c.state = S_FETCH; c.mem_read = 1'b1; c.alu_src_b = 2'b01; c.alu_op = 4'b0001;
    c.ir_write = rdy; c.pc_write = rdy; return c;
  endfunction
  function automatic ctl_t x_decode();
    ctl_t c = '0; c.state = S_DECODE; c.alu_src_b = 2'b11; c.alu_op = 4'b0001; c.sign_ext = 1'b1; return c;
  endfunction
  function automatic ctl_t x_exec_r(logic [1:0] sa, logic [3:0] ao);
    ctl_t c = '0; c.state = S_EXEC_R; c.alu_src_a = sa; c.alu_op = ao; return c;
  endfunction
  function automatic ctl_t x_exec_i(logic [3:0] ao, logic se);
    ctl_t c = '0; c.state = S_EXEC_I; c.alu_src_a = 2'b01; c.alu_src_b = 2'b10; c.alu_op = ao;
    c.sign_ext = se; return c;
  endfunction
  function automatic ctl_t x_wb(logic rd);
    ctl_t c = '0; c.state = S_WB_ALU; c.reg_write = 1'b1; c.reg_dst = rd; c.instr_done = 1'b1; return c;
  endfunction
  function automatic ctl_t x_maddr();
    ctl_t c = '0; c.state = S_MEM_ADDR; c.alu_src_a = 2'b01; c.alu_src_b = 2'b10; c.alu_op = 4'b0001;
    c.sign_ext = 1'b1; return c;
  endfunction
  function automatic ctl_t x_mrd();
    ctl_t c = '0; c.state = S_MEM_RD; c.mem_read = 1'b1; c.i_or_d = 1'b1; return c;
  endfunction
  function automatic ctl_t x_mwb();
    ctl_t c = '0; c.state = S_MEM_WB; c.reg_write = 1'b1; c.mem_to_reg = 1'b1; c.instr_done = 1'b1; return c;
  endfunction
  function automatic ctl_t x_mwr(logic rdy);
    ctl_t c = '0; c.state = S_MEM_WR; c.mem_write = 1'b1; c.i_or_d = 1'b1; c.instr_done = rdy; return c;
  endfunction
  function automatic ctl_t x_br(logic ne);
    ctl_t c = '0; c.state = S_BRANCH; c.alu_src_a = 2'b01; c.alu_op = 4'b0010; c.pc_write_cond = 1'b1;
    c.branch_ne = ne; c.pc_source = 2'b01; c.instr_done = 1'b1; return c;
  endfunction
  function automatic ctl_t x_jump();
    ctl_t c = '0; c.state = S_JUMP; c.pc_write = 1'b1; c.pc_source = 2'b10; c.instr_done = 1'b1; return c;
  endfunction
  function automatic ctl_t x_trap();
    ctl_t c = '0; c.state = S_TRAP; c.illegal = 1'b1; return c;
  endfunction

  function automatic vec_t v(logic r, logic [5:0] o, logic [5:0] f, logic rdy, ctl_t e);
    vec_t t; t.rst_n = r; t.op = o; t.funct = f; t.mem_ready = rdy; t.exp = e; return t;
  endfunction

  task automatic chk(input string nm, input ctl_t got, input ctl_t exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s step %0d: got %h (state %0d) want %h (state %0d)",
               nm, step_no, got, got.state, exp, exp.state);
    end
  endtask

  // One clock cycle: drive inputs just after the edge, push expectations, compare mid-cycle.
  task automatic step(input logic r, input logic [5:0] o, input logic [5:0] f,
                      input logic rdy, input ctl_t e1, input ctl_t e0);
    pair_t p;
    @(posedge clk); #1;
    rst_n = r; op = o; funct = f; mem_ready = rdy; zero = 1'($urandom_range(0, 1));
    sbq.push_back('{e1: e1, e0: e0});
    @(negedge clk);
    step_no++;
    if (sbq.size() == 0) begin
      n_cmp++; n_bad++;
      $display("FAIL scoreboard step %0d: got empty queue want one entry", step_no);
    end else begin
      p = sbq.pop_front();
      chk("trap_dut", got1, p.e1);
      chk("nop_dut", got0, p.e0);
    end
  endtask

  task automatic step2(input logic r, input logic [5:0] o, input logic [5:0] f,
                       input logic rdy, input ctl_t e);
    step(r, o, f, rdy, e, e);
  endtask

  localparam logic [5:0] R = 6'b000000, LW = 6'b100011, SW = 6'b101011, ORI = 6'b001101;
  localparam logic [5:0] ADDI = 6'b001000, XORI = 6'b001110, BNE = 6'b000101, BEQ = 6'b000100;
  localparam logic [5:0] J = 6'b000010, BAD = 6'b111111;

  initial begin
    rst_n = 1'b0; op = '0; funct = '0; zero = 1'b0; mem_ready = 1'b0;
    repeat (2) @(posedge clk);

    // reset state, then add
    vecs.push_back(v(1, R, 6'b100000, 1, x_idle()));
    vecs.push_back(v(1, R, 6'b100000, 1, x_fetch(1)));
    vecs.push_back(v(1, R, 6'b100000, 1, x_decode()));
    vecs.push_back(v(1, R, 6'b100000, 0, x_exec_r(2'b01, 4'b0000)));
    vecs.push_back(v(1, R, 6'b100000, 1, x_wb(1)));
    // sll, srlv, sra, sltu, nor, sub
    vecs.push_back(v(1, R, 6'b000000, 1, x_fetch(1)));
    vecs.push_back(v(1, R, 6'b000000, 0, x_decode()));
    vecs.push_back(v(1, R, 6'b000000, 1, x_exec_r(2'b10, 4'b1010)));
    vecs.push_back(v(1, R, 6'b000000, 0, x_wb(1)));
    vecs.push_back(v(1, R, 6'b000110, 1, x_fetch(1)));
    vecs.push_back(v(1, R, 6'b000110, 1, x_decode()));
    vecs.push_back(v(1, R, 6'b000110, 1, x_exec_r(2'b01, 4'b1011)));
    vecs.push_back(v(1, R, 6'b000110, 1, x_wb(1)));
    vecs.push_back(v(1, R, 6'b000011, 1, x_fetch(1)));
    vecs.push_back(v(1, R, 6'b000011, 0, x_decode()));
    vecs.push_back(v(1, R, 6'b000011, 0, x_exec_r(2'b10, 4'b1100)));
    vecs.push_back(v(1, R, 6'b000011, 0, x_wb(1)));
    vecs.push_back(v(1, R, 6'b101011, 1, x_fetch(1)));
    vecs.push_back(v(1, R, 6'b101011, 1, x_decode()));
    vecs.push_back(v(1, R, 6'b101011, 1, x_exec_r(2'b01, 4'b1001)));
    vecs.push_back(v(1, R, 6'b101011, 1, x_wb(1)));
    vecs.push_back(v(1, R, 6'b100111, 1, x_fetch(1)));
    vecs.push_back(v(1, R, 6'b100111, 1, x_decode()));
    vecs.push_back(v(1, R, 6'b100111, 1, x_exec_r(2'b01, 4'b0111)));
    vecs.push_back(v(1, R, 6'b100111, 1, x_wb(1)));
    vecs.push_back(v(1, R, 6'b100010, 1, x_fetch(1)));
    vecs.push_back(v(1, R, 6'b100010, 1, x_decode()));
    vecs.push_back(v(1, R, 6'b100010, 1, x_exec_r(2'b01, 4'b0010)));
    vecs.push_back(v(1, R, 6'b100010, 1, x_wb(1)));
    // ori, addi, xori
    vecs.push_back(v(1, ORI, 6'b100000, 1, x_fetch(1)));
    vecs.push_back(v(1, ORI, 6'b100000, 1, x_decode()));
    vecs.push_back(v(1, ORI, 6'b100000, 1, x_exec_i(4'b0101, 0)));
    vecs.push_back(v(1, ORI, 6'b100000, 1, x_wb(0)));
    vecs.push_back(v(1, ADDI, 6'b000000, 1, x_fetch(1)));
    vecs.push_back(v(1, ADDI, 6'b000000, 1, x_decode()));
    vecs.push_back(v(1, ADDI, 6'b000000, 1, x_exec_i(4'b0000, 1)));
    vecs.push_back(v(1, ADDI, 6'b000000, 1, x_wb(0)));
    vecs.push_back(v(1, XORI, 6'b111111, 1, x_fetch(1)));
    vecs.push_back(v(1, XORI, 6'b111111, 1, x_decode()));
    vecs.push_back(v(1, XORI, 6'b111111, 1, x_exec_i(4'b0110, 0)));
    vecs.push_back(v(1, XORI, 6'b111111, 1, x_wb(0)));
    // lw with three MEM_RD wait cycles: 8 cycles total
    vecs.push_back(v(1, LW, 6'b000000, 1, x_fetch(1)));
    vecs.push_back(v(1, LW, 6'b000000, 1, x_decode()));
    vecs.push_back(v(1, LW, 6'b000000, 1, x_maddr()));
    vecs.push_back(v(1, LW, 6'b000000, 0, x_mrd()));
    vecs.push_back(v(1, LW, 6'b000000, 0, x_mrd()));
    vecs.push_back(v(1, LW, 6'b000000, 0, x_mrd()));
    vecs.push_back(v(1, LW, 6'b000000, 1, x_mrd()));
    vecs.push_back(v(1, LW, 6'b000000, 1, x_mwb()));
    // sw with a fetch wait and two write waits
    vecs.push_back(v(1, SW, 6'b000000, 0, x_fetch(0)));
    vecs.push_back(v(1, SW, 6'b000000, 1, x_fetch(1)));
    vecs.push_back(v(1, SW, 6'b000000, 1, x_decode()));
    vecs.push_back(v(1, SW, 6'b000000, 0, x_maddr()));
    vecs.push_back(v(1, SW, 6'b000000, 0, x_mwr(0)));
    vecs.push_back(v(1, SW, 6'b000000, 0, x_mwr(0)));
    vecs.push_back(v(1, SW, 6'b000000, 1, x_mwr(1)));
    // bne, beq, j
    vecs.push_back(v(1, BNE, 6'b000000, 1, x_fetch(1)));
    vecs.push_back(v(1, BNE, 6'b000000, 1, x_decode()));
    vecs.push_back(v(1, BNE, 6'b000000, 1, x_br(1)));
    vecs.push_back(v(1, BEQ, 6'b000000, 1, x_fetch(1)));
    vecs.push_back(v(1, BEQ, 6'b000000, 1, x_decode()));
    vecs.push_back(v(1, BEQ, 6'b000000, 1, x_br(0)));
    vecs.push_back(v(1, J, 6'b000000, 1, x_fetch(1)));
    vecs.push_back(v(1, J, 6'b000000, 1, x_decode()));
    vecs.push_back(v(1, J, 6'b000000, 1, x_jump()));

    for (int i = 0; i < vecs.size(); i++)
      step2(vecs[i].rst_n, vecs[i].op, vecs[i].funct, vecs[i].mem_ready, vecs[i].exp);

    // reset held two cycles in the middle of a MEM_RD wait; the late mem_ready is ignored
    step2(1, LW, 6'b000000, 1, x_fetch(1));
    step2(1, LW, 6'b000000, 0, x_decode());
    step2(1, LW, 6'b000000, 0, x_maddr());
    step2(1, LW, 6'b000000, 0, x_mrd());
    step2(0, LW, 6'b000000, 0, x_mrd());
    step2(0, LW, 6'b000000, 1, x_idle());
    step2(1, LW, 6'b000000, 1, x_idle());
    step2(1, LW, 6'b000000, 0, x_fetch(0));

    // op 0 with an unlisted funct: sticky trap vs. silent return to FETCH
    step2(1, R, 6'b000001, 1, x_fetch(1));
    step2(1, R, 6'b000001, 0, x_decode());
    step (1, R, 6'b000001, 0, x_trap(), x_fetch(0));
    step (1, R, 6'b000001, 1, x_trap(), x_fetch(1));
    step (1, R, 6'b000001, 1, x_trap(), x_decode());
    step (1, R, 6'b000001, 0, x_trap(), x_fetch(0));
    step (0, R, 6'b000001, 0, x_trap(), x_fetch(0));
    step2(1, BAD, 6'b000000, 1, x_idle());

    // undecoded opcode
    step2(1, BAD, 6'b000000, 1, x_fetch(1));
    step2(1, BAD, 6'b000000, 1, x_decode());
    step (1, BAD, 6'b000000, 0, x_trap(), x_fetch(0));
    step (1, BAD, 6'b000000, 1, x_trap(), x_fetch(1));
    step (1, BAD, 6'b000000, 1, x_trap(), x_decode());
    step (1, BAD, 6'b000000, 1, x_trap(), x_fetch(1));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
- Moore-style FSM that sequences the shared single-ALU, single-memory multicycle datapath through FETCH/DECODE/EXECUTE/MEM/WB.
- Covers the same ISA subset as the combinational decoder: R-type ALU and shift ops, addi/addiu/andi/ori/xori, lw/sw, beq/bne, j.
- Drives datapath muxes, write enables and ALU function.
- Waits on a variable-latency memory ready handshake.

Parameters:
TRAP_ON_ILLEGAL, 1, 1: an undecoded op/funct enters sticky TRAP; 0: treat it as NOP and return to FETCH.

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  reset, synchronous, active-low
op  input  6  IR[31:26]; stable from the DECODE cycle onward
funct  input  6  IR[5:0]
zero  input  1  ALU zero flag
mem_ready  input  1  memory completes the current access this cycle
pc_write  output  1  unconditional PC load
pc_write_cond  output  1  PC load when (zero ^ branch_ne)
branch_ne  output  1  1 = bne sense
i_or_d  output  1  memory address: 0 = PC, 1 = ALUOut
ir_write  output  1  IR load
mem_read  output  1  memory read request
mem_write  output  1  memory write request
reg_write  output  1  register-file write enable
reg_dst  output  1  1 = rd, 0 = rt
mem_to_reg  output  1  1 = MDR, 0 = ALUOut
alu_src_a  output  2  00 = PC, 01 = rs, 10 = shamt
alu_src_b  output  2  00 = rt, 01 = const 4, 10 = ext imm, 11 = ext imm<<2
alu_op  output  4  ALU function code
sign_ext  output  1  1 = sign-extend imm, 0 = zero-extend
pc_source  output  2  00 = ALU result, 01 = ALUOut, 10 = jump target
instr_done  output  1  one-cycle pulse on the final cycle of each instruction
illegal  output  1  high while in TRAP
state  output  4  current state (debug)

Behaviour:
- States: IDLE, FETCH, DECODE, EXEC_R, EXEC_I, WB_ALU, MEM_ADDR, MEM_RD, MEM_WB, MEM_WR, BRANCH, JUMP, TRAP.
- Outputs are decoded from state plus internal flags latched in DECODE: is_r, is_bne, is_lw, shift_imm.
- Any output not listed for a state is 0.
- Reset: rst_n low at a clock edge -> IDLE next cycle, from any state, including mid memory wait. Outputs all 0. A late mem_ready is ignored. IDLE -> FETCH unconditionally.
- alu_op codes:
  - add 0000, addu 0001, sub 0010, subu 0011
  - and 0100, or 0101, xor 0110, nor 0111
  - slt 1000, sltu 1001
  - sll/sllv 1010, srl/srlv 1011, sra/srav 1100
- FETCH:
  - mem_read = 1, i_or_d = 0, alu_src_a = 00, alu_src_b = 01, alu_op = 0001, pc_source = 00.
  - ir_write = pc_write = mem_ready.
  - Stay while !mem_ready; on mem_ready -> DECODE.
- DECODE:
  - alu_src_a = 00, alu_src_b = 11, alu_op = 0001, sign_ext = 1 (branch target into ALUOut).
  - Latch flags, then dispatch: R-type -> EXEC_R; imm ALU -> EXEC_I; lw/sw -> MEM_ADDR; beq/bne -> BRANCH; j -> JUMP; otherwise TRAP or FETCH per TRAP_ON_ILLEGAL.
  - op = 0 with an unlisted funct is illegal.
- EXEC_R:
  - alu_src_a = 10 for sll/srl/sra, else 01; alu_src_b = 00; alu_op per funct.
  - -> WB_ALU.
- EXEC_I:
  - alu_src_a = 01, alu_src_b = 10.
  - alu_op: addi 0000, addiu 0001, andi 0100, ori 0101, xori 0110.
  - sign_ext = 1 for addi/addiu, 0 for andi/ori/xori.
  - -> WB_ALU.
- WB_ALU: reg_write = 1, mem_to_reg = 0, reg_dst = is_r, instr_done = 1. -> FETCH.
- MEM_ADDR: alu_src_a = 01, alu_src_b = 10, alu_op = 0001, sign_ext = 1. -> MEM_RD if lw, MEM_WR if sw.
- MEM_RD: mem_read = 1, i_or_d = 1. Hold until mem_ready, then -> MEM_WB.
- MEM_WB: reg_write = 1, mem_to_reg = 1, reg_dst = 0, instr_done = 1. -> FETCH.
- MEM_WR:
  - mem_write = 1, i_or_d = 1; held until mem_ready.
  - On mem_ready: instr_done = 1, -> FETCH.
- BRANCH: alu_src_a = 01, alu_src_b = 00, alu_op = 0010, pc_write_cond = 1, branch_ne = is_bne, pc_source = 01, instr_done = 1. -> FETCH.
- JUMP: pc_write = 1, pc_source = 10, instr_done = 1. -> FETCH.
- TRAP: illegal = 1, all other outputs 0; exits only via reset.
- Memory request contract:
  - mem_read/mem_write stay asserted continuously until mem_ready is sampled high.
  - mem_ready outside FETCH/MEM_RD/MEM_WR is ignored.
- Latency with mem_ready tied high: R/I 4 cycles, lw 5, sw 4, beq/bne 3, j 3.
- Each extra wait cycle adds exactly 1 cycle.

Test Plan:
- rst_n = 0 for 2 cycles mid-MEM_RD with mem_ready = 0 -> IDLE, all outputs 0; next cycle FETCH with mem_read = 1.
- add (op 0, funct 100000), mem_ready = 1 -> EXEC_R alu_op = 0000, alu_src_a = 01; WB_ALU reg_write = 1, reg_dst = 1; instr_done in cycle 4.
- sll (funct 000000) -> EXEC_R alu_src_a = 10, alu_op = 1010. ori (op 001101) -> alu_op = 0101, sign_ext = 0, reg_dst = 0.
- lw (op 100011) with mem_ready low 3 cycles in MEM_RD -> mem_read and i_or_d = 1 held 4 cycles, then MEM_WB mem_to_reg = 1; total 8 cycles.
- bne (op 000101) -> BRANCH with pc_write_cond = 1, branch_ne = 1, alu_op = 0010, pc_source = 01. j (op 000010) -> pc_write = 1, pc_source = 10.
- op 111111: TRAP_ON_ILLEGAL = 1 -> illegal = 1 held until reset; TRAP_ON_ILLEGAL = 0 -> DECODE then FETCH, no write enables asserted.
